// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the input conditioner and the central pet FSM:
// test-mode FSM encodings, selection code constants and the wrap helper.
package input_conditioner_pkg;

    typedef enum logic [1:0] {
        T_IDLE    = 2'd0,
        T_HOLD    = 2'd1,
        T_ENTERED = 2'd2,
        T_SELECT  = 2'd3
    } test_state_t;

    localparam int SEL_MAX_DEFAULT = 9;

    // test_sel codes; 0 means no selection has been made yet
    localparam logic [3:0] SEL_NONE    = 4'd0;
    localparam logic [3:0] SEL_IDLE    = 4'd1;
    localparam logic [3:0] SEL_NEUTRAL = 4'd2;
    localparam logic [3:0] SEL_TIRED   = 4'd3;
    localparam logic [3:0] SEL_SLEEP   = 4'd4;
    localparam logic [3:0] SEL_HUNGRY  = 4'd5;
    localparam logic [3:0] SEL_SAD     = 4'd6;
    localparam logic [3:0] SEL_PLAYING = 4'd7;
    localparam logic [3:0] SEL_BORED   = 4'd8;
    localparam logic [3:0] SEL_DEATH   = 4'd9;

    // Advance a selection code, wrapping from sel_max back to the first code
    function automatic logic [3:0] next_sel(input logic [3:0] sel, input logic [3:0] sel_max);
        return (sel >= sel_max) ? SEL_IDLE : sel + 4'd1;
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One raw input channel: polarity fix, 2-flop synchroniser, stability
// counter, debounced level and a one-cycle pulse on each 0->1 level change.
module debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          pressed;
    logic          sync1_reg;
    logic          sync2_reg;
    logic          stable_reg;
    logic          stable_d_reg;
    logic          pulse_reg;
    logic [CW-1:0] cnt_reg;

    assign pressed = (ACTIVE_LOW != 0) ? ~raw : raw;

    // Two-flop synchroniser for the asynchronous board input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= pressed;
            sync2_reg <= sync1_reg;
        end
    end

    // Stable level only follows after DEBOUNCE_CYCLES consecutive mismatching samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg    <= '0;
            stable_reg <= 1'b0;
        end else if (sync2_reg == stable_reg) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            stable_reg <= sync2_reg;
            cnt_reg    <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Registered rising-edge detect of the stable level; releases give nothing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_d_reg <= 1'b0;
            pulse_reg    <= 1'b0;
        end else begin
            stable_d_reg <= stable_reg;
            pulse_reg    <= stable_reg & ~stable_d_reg;
        end
    end

    assign level      = stable_reg;
    assign rise_pulse = pulse_reg;

endmodule

// File: rtl/input_conditioner.sv
// Front end for the pet FSM: debounces the five buttons and the tilt switch,
// emits command pulses, and runs the long-press test-mode selection FSM.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int ACTIVE_LOW       = 1,
    parameter int DEBOUNCE_CYCLES  = 500000,
    parameter int TEST_HOLD_CYCLES = 100000000,
    parameter int SEL_MAX          = SEL_MAX_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_sleep_raw,
    input  logic       btn_awake_raw,
    input  logic       btn_feed_raw,
    input  logic       btn_play_raw,
    input  logic       btn_test_raw,
    input  logic       tilt_raw,
    output logic       sleep_pulse,
    output logic       awake_pulse,
    output logic       feed_pulse,
    output logic       play_pulse,
    output logic       giro,
    output logic       test_active,
    output logic [3:0] test_sel
);

    localparam int HW = $clog2(TEST_HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(TEST_HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_SAT  = {HW{1'b1}};
    localparam logic [3:0]    SEL_MAX_L = 4'(SEL_MAX);

    // Channel order: 0 sleep, 1 awake, 2 feed, 3 play, 4 tilt, 5 test
    logic [5:0] raw_vec;
    logic [5:0] level_vec;
    logic [5:0] rise_vec;

    assign raw_vec = {btn_test_raw, tilt_raw, btn_play_raw, btn_feed_raw, btn_awake_raw, btn_sleep_raw};

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_chan
            debounce_channel #(
                .ACTIVE_LOW      (ACTIVE_LOW),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_chan (
                .clk        (clk),
                .rst        (rst),
                .raw        (raw_vec[gi]),
                .level      (level_vec[gi]),
                .rise_pulse (rise_vec[gi])
            );
        end
    endgenerate

    // Button levels and the tilt edge are not needed by this block
    logic unused_sigs;
    assign unused_sigs = ^{level_vec[3:0], rise_vec[4]};

    logic test_level;
    logic test_rise;
    logic play_rise;

    assign test_level = level_vec[5];
    assign test_rise  = rise_vec[5];
    assign play_rise  = rise_vec[3];

    test_state_t   state_reg,    state_next;
    logic [HW-1:0] hold_reg,     hold_next;
    logic          active_reg,   active_next;
    logic [3:0]    sel_reg,      sel_next;
    logic          active_d_reg;

    // Test FSM state and its registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= T_IDLE;
            hold_reg     <= '0;
            active_reg   <= 1'b0;
            sel_reg      <= SEL_NONE;
            active_d_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            hold_reg     <= hold_next;
            active_reg   <= active_next;
            sel_reg      <= sel_next;
            active_d_reg <= active_reg;
        end
    end

    // Test FSM next state: long press enters, play advances, test exits once a code is chosen
    always_comb begin
        state_next  = state_reg;
        hold_next   = hold_reg;
        active_next = active_reg;
        sel_next    = sel_reg;
        case (state_reg)
            T_IDLE: begin
                if (test_rise) begin
                    state_next = T_HOLD;
                    hold_next  = '0;
                end
            end
            T_HOLD: begin
                if (!test_level) begin
                    state_next = T_IDLE;
                end else if (hold_reg == HOLD_LAST) begin
                    state_next  = T_ENTERED;
                    active_next = 1'b1;
                    sel_next    = SEL_NONE;
                end else if (hold_reg != HOLD_SAT) begin
                    hold_next = hold_reg + 1'b1;
                end
            end
            T_ENTERED: begin
                if (!test_level) begin
                    state_next = T_SELECT;
                end
            end
            T_SELECT: begin
                if (play_rise) begin
                    sel_next = next_sel(sel_reg, SEL_MAX_L);
                end
                // Leaving with no selection would strand the pet FSM in test mode
                if (test_rise && (sel_reg != SEL_NONE)) begin
                    state_next  = T_IDLE;
                    active_next = 1'b0;
                end
            end
            default: state_next = T_IDLE;
        endcase
    end

    // Commands are suppressed in test mode and on the cycle it ends
    logic cmd_mask;
    assign cmd_mask = active_reg | active_d_reg;

    assign sleep_pulse = rise_vec[0] & ~cmd_mask;
    assign awake_pulse = rise_vec[1] & ~cmd_mask;
    assign feed_pulse  = rise_vec[2] & ~cmd_mask;
    assign play_pulse  = rise_vec[3] & ~cmd_mask;
    assign giro        = level_vec[4];
    assign test_active = active_reg;
    assign test_sel    = sel_reg;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner with short debounce/hold times.
module tb_input_conditioner;

    localparam int D = 4;
    localparam int H = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_sleep_raw = 1'b1;
    logic       btn_awake_raw = 1'b1;
    logic       btn_feed_raw  = 1'b1;
    logic       btn_play_raw  = 1'b1;
    logic       btn_test_raw  = 1'b1;
    logic       tilt_raw      = 1'b1;
    logic       sleep_pulse, awake_pulse, feed_pulse, play_pulse;
    logic       giro, test_active;
    logic [3:0] test_sel;

    always #5 clk = ~clk;

    input_conditioner #(
        .ACTIVE_LOW       (1),
        .DEBOUNCE_CYCLES  (D),
        .TEST_HOLD_CYCLES (H),
        .SEL_MAX          (9)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_sleep_raw (btn_sleep_raw),
        .btn_awake_raw (btn_awake_raw),
        .btn_feed_raw  (btn_feed_raw),
        .btn_play_raw  (btn_play_raw),
        .btn_test_raw  (btn_test_raw),
        .tilt_raw      (tilt_raw),
        .sleep_pulse   (sleep_pulse),
        .awake_pulse   (awake_pulse),
        .feed_pulse    (feed_pulse),
        .play_pulse    (play_pulse),
        .giro          (giro),
        .test_active   (test_active),
        .test_sel      (test_sel)
    );

    int n_tests  = 0;
    int n_failed = 0;
    int n_pulse [4];
    int giro_seen;
    int active_seen;

    typedef struct {
        int ch;
        int len;
        int exp;
    } vec_t;
    vec_t vecs [10];

    // Reference model: a level follows once the last D synchronised samples agree
    bit hist [5][D+2];
    bit lvl  [5];
    bit lvl1 [5];
    bit lvl2 [5];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_raw(input int ch, input logic v);
        case (ch)
            0: btn_sleep_raw = v;
            1: btn_awake_raw = v;
            2: btn_feed_raw  = v;
            3: btn_play_raw  = v;
            4: tilt_raw      = v;
            default: btn_test_raw = v;
        endcase
    endtask

    function automatic logic raw_of(input int ch);
        case (ch)
            0: return btn_sleep_raw;
            1: return btn_awake_raw;
            2: return btn_feed_raw;
            3: return btn_play_raw;
            4: return tilt_raw;
            default: return btn_test_raw;
        endcase
    endfunction

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) n_pulse[i] = 0;
        giro_seen   = 0;
        active_seen = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        n_pulse[0] += int'(sleep_pulse);
        n_pulse[1] += int'(awake_pulse);
        n_pulse[2] += int'(feed_pulse);
        n_pulse[3] += int'(play_pulse);
        if (giro) giro_seen = 1;
        if (test_active) active_seen = 1;
    endtask

    task automatic press(input int ch, input int len, input int gap);
        set_raw(ch, 1'b0);
        repeat (len) tick();
        set_raw(ch, 1'b1);
        repeat (gap) tick();
    endtask

    task automatic enter_test(output int entry);
        entry = -1;
        set_raw(5, 1'b0);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (test_active && entry < 0) entry = i;
        end
        set_raw(5, 1'b1);
        repeat (20) tick();
    endtask

    task automatic model_reset();
        for (int c = 0; c < 5; c++) begin
            for (int k = 0; k < D + 2; k++) hist[c][k] = 1'b0;
            lvl[c]  = 1'b0;
            lvl1[c] = 1'b0;
            lvl2[c] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit agree;
        for (int c = 0; c < 5; c++) begin
            for (int k = D + 1; k > 0; k--) hist[c][k] = hist[c][k-1];
            hist[c][0] = ~raw_of(c);
            lvl2[c] = lvl1[c];
            lvl1[c] = lvl[c];
            agree = 1'b1;
            for (int k = 2; k <= D + 1; k++) if (hist[c][k] == lvl[c]) agree = 1'b0;
            if (agree) lvl[c] = ~lvl[c];
        end
    endtask

    initial begin
        int   e;
        int   first_edge;
        int   others;
        logic [5:0] act_v, exp_v;

        vecs[0] = '{2, 3, 0};
        vecs[1] = '{2, 4, 1};
        vecs[2] = '{0, 2, 0};
        vecs[3] = '{0, 9, 1};
        vecs[4] = '{1, 4, 1};
        vecs[5] = '{1, 1, 0};
        vecs[6] = '{3, 5, 1};
        vecs[7] = '{4, 3, 0};
        vecs[8] = '{4, 4, 1};
        vecs[9] = '{4, 10, 1};

        // Reset state
        repeat (3) tick();
        check("reset_sleep", int'(sleep_pulse), 0);
        check("reset_awake", int'(awake_pulse), 0);
        check("reset_feed", int'(feed_pulse), 0);
        check("reset_play", int'(play_pulse), 0);
        check("reset_giro", int'(giro), 0);
        check("reset_test_active", int'(test_active), 0);
        check("reset_test_sel", int'(test_sel), 0);
        rst = 1'b0;
        repeat (2) tick();

        // Table: press length against the debounce threshold
        for (int r = 0; r < 10; r++) begin
            clear_counts();
            press(vecs[r].ch, vecs[r].len, 14);
            others = n_pulse[0] + n_pulse[1] + n_pulse[2] + n_pulse[3];
            if (vecs[r].ch == 4) begin
                check($sformatf("vec%0d_giro", r), giro_seen, vecs[r].exp);
            end else begin
                check($sformatf("vec%0d_pulses", r), n_pulse[vecs[r].ch], vecs[r].exp);
                others -= n_pulse[vecs[r].ch];
            end
            check($sformatf("vec%0d_other_pulses", r), others, 0);
            $display("[TB] vec %0d ch=%0d len=%0d exp=%0d", r, vecs[r].ch, vecs[r].len, vecs[r].exp);
        end

        // Feed bounce then a steady press starting at edge 8
        clear_counts();
        first_edge = -1;
        for (int i = 0; i < 40; i++) begin
            set_raw(2, (i < 10 && ((i / 2) % 2 == 1)) ? 1'b1 : 1'b0);
            tick();
            if (feed_pulse && first_edge < 0) first_edge = i;
        end
        set_raw(2, 1'b1);
        repeat (10) tick();
        check("bounce_pulse_count", n_pulse[2], 1);
        check("bounce_pulse_edge", first_edge, 14);
        $display("[TB] feed bounce: pulses=%0d edge=%0d", n_pulse[2], first_edge);

        // Tilt latency: giro rises on the 6th edge of the low level
        set_raw(4, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 4) check("tilt_before_latency", int'(giro), 0);
            if (i == 5) check("tilt_at_latency", int'(giro), 1);
        end
        set_raw(4, 1'b1);
        repeat (12) tick();
        check("tilt_released", int'(giro), 0);
        $display("[TB] tilt latency sequence done");

        // Short test press
        clear_counts();
        press(5, 12, 20);
        check("short_test_active", active_seen, 0);
        check("short_test_sel", int'(test_sel), 0);
        check("short_test_pulses", n_pulse[0] + n_pulse[1] + n_pulse[2] + n_pulse[3], 0);
        $display("[TB] short test press: active_seen=%0d", active_seen);

        // Long press, then select through the wrap
        enter_test(e);
        check("entry_edge", e, 27);
        check("entered_active", int'(test_active), 1);
        check("entered_sel", int'(test_sel), 0);
        clear_counts();
        for (int k = 1; k <= 10; k++) begin
            press(3, 6, 10);
            check($sformatf("sel_after_play%0d", k), int'(test_sel), ((k - 1) % 9) + 1);
            $display("[TB] play press %0d: test_sel=%0d", k, test_sel);
        end
        check("select_play_pulses", n_pulse[3], 0);
        press(5, 6, 10);
        check("exit_active", int'(test_active), 0);
        check("exit_sel_held", int'(test_sel), 1);

        // Exit guard with no selection, commands masked in test mode
        enter_test(e);
        press(5, 6, 10);
        check("guard_active", int'(test_active), 1);
        check("guard_sel", int'(test_sel), 0);
        clear_counts();
        press(2, 6, 10);
        check("masked_feed", n_pulse[2], 0);
        for (int k = 0; k < 3; k++) press(3, 6, 10);
        check("guard_play_pulses", n_pulse[3], 0);
        press(5, 6, 10);
        check("guard_exit_active", int'(test_active), 0);
        check("guard_exit_sel", int'(test_sel), 3);
        $display("[TB] exit guard: sel=%0d", test_sel);

        // Reset in the middle of the hold count
        set_raw(5, 1'b0);
        repeat (18) tick();
        rst = 1'b1;
        #1;
        check("async_rst_sel", int'(test_sel), 0);
        check("async_rst_active", int'(test_active), 0);
        check("async_rst_giro", int'(giro), 0);
        set_raw(5, 1'b1);
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();
        enter_test(e);
        check("reentry_edge", e, 27);
        check("reentry_active", int'(test_active), 1);
        $display("[TB] reset mid-hold: reentry edge=%0d", e);

        // Randomised channels against the reference model
        rst = 1'b1;
        for (int c = 0; c < 6; c++) set_raw(c, 1'b1);
        repeat (2) tick();
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 800; n++) begin
            tick();
            model_step();
            act_v = {test_active, giro, play_pulse, feed_pulse, awake_pulse, sleep_pulse};
            exp_v = {1'b0, lvl[4],
                     lvl1[3] & ~lvl2[3], lvl1[2] & ~lvl2[2],
                     lvl1[1] & ~lvl2[1], lvl1[0] & ~lvl2[0]};
            check($sformatf("rand_cycle%0d", n), int'(act_v), int'(exp_v));
            for (int c = 0; c < 5; c++) begin
                if ($urandom_range(0, 5) == 0) set_raw(c, ~raw_of(c));
            end
        end
        $display("[TB] random phase: 800 cycles");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
